// File: rtl/mem_if_pkg.sv
// Shared encodings for the CPU data-RAM port: FSM states, access
// sizes and the read write-enable code.
package mem_if_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_t;

   localparam logic [1:0] SZ_BYTE  = 2'b00;
   localparam logic [1:0] SZ_HALF  = 2'b01;
   localparam logic [1:0] SZ_WORD  = 2'b10;
   localparam logic [3:0] WEA_READ = 4'b0000;

   // Alignment and size legality; range is checked by the user
   function automatic logic misaligned(
      input logic [1:0] size,
      input logic [1:0] lsb
   );
      logic bad;
      bad = 1'b1;
      unique case (size)
         SZ_BYTE: bad = 1'b0;
         SZ_HALF: bad = lsb[0];
         SZ_WORD: bad = (lsb != 2'b00);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port word SRAM with four byte-lane write enables and a
// registered read port that clears on reset.
module dmem_sram_array
   import mem_if_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] idx,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata
);

   logic [31:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (en && we != WEA_READ) begin
         for (int b = 0; b < 4; b++) begin
            if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= 32'h0;
      end else if (en && we == WEA_READ) begin
         rdata <= mem[idx];
      end
   end

endmodule

// File: rtl/data_ram_responder.sv
// Target side of the CPU data-RAM port: wait-state FSM, request
// latch and access checking in front of a byte-writable SRAM.
module data_ram_responder
   import mem_if_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clka,
   input  logic        rst,
   input  logic        data_ram_ena,
   input  logic [3:0]  data_ram_wea,
   input  logic [1:0]  data_ram_size,
   input  logic [31:0] data_ram_addr,
   input  logic [31:0] data_ram_wdata,
   output logic [31:0] data_ram_rdata,
   output logic        stall,
   output logic        addr_err
);

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic        go_done;

   logic [3:0]  wea_q;
   logic [1:0]  size_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic [3:0]  wea_c;
   logic [1:0]  size_c;
   logic [31:0] addr_c;
   logic [31:0] wdata_c;
   logic        err_c;
   logic        acc_en;

   always_ff @(posedge clka) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      stall    = 1'b0;
      go_done  = 1'b0;
      unique case (state)
         IDLE: begin
            stall = data_ram_ena;
            if (data_ram_ena) begin
               if (WAIT_CYCLES == 0) begin
                  state_nx = DONE;
                  go_done  = 1'b1;
               end else begin
                  state_nx = BUSY;
                  cnt_nx   = CNT_INIT;
               end
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (cnt == 4'd0) begin
               state_nx = DONE;
               go_done  = 1'b1;
            end else begin
               cnt_nx = cnt - 4'd1;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clka) begin
      if (rst) begin
         wea_q   <= WEA_READ;
         size_q  <= SZ_BYTE;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
      end else if (state == IDLE && data_ram_ena) begin
         wea_q   <= data_ram_wea;
         size_q  <= data_ram_size;
         addr_q  <= data_ram_addr;
         wdata_q <= data_ram_wdata;
      end
   end

   // With no wait states the access fires from IDLE, before the latch
   always_comb begin
      if (state == IDLE) begin
         wea_c   = data_ram_wea;
         size_c  = data_ram_size;
         addr_c  = data_ram_addr;
         wdata_c = data_ram_wdata;
      end else begin
         wea_c   = wea_q;
         size_c  = size_q;
         addr_c  = addr_q;
         wdata_c = wdata_q;
      end
   end

   assign err_c = misaligned(size_c, addr_c[1:0])
                | ((addr_c >> (ADDR_W + 2)) != 32'h0);

   assign acc_en = go_done & ~err_c & ~rst;

   always_ff @(posedge clka) begin
      if (rst) begin
         addr_err <= 1'b0;
      end else begin
         addr_err <= go_done & err_c;
      end
   end

   dmem_sram_array #(
      .ADDR_W (ADDR_W)
   ) u_sram (
      .clk   (clka),
      .rst   (rst),
      .en    (acc_en),
      .we    (wea_c),
      .idx   (addr_c[ADDR_W+1:2]),
      .wdata (wdata_c),
      .rdata (data_ram_rdata)
   );

endmodule
